bus_responder: RTL and testbench

Bus-side endpoint of the time-multiplexed 8-bit address bus that connects each cache's bus interface to the shared bus. It captures addresses arriving on the bus into a receive FIFO and hands them to the local memory/snoop logic over a valid/ready port. It also takes response addresses from that logic into a transmit FIFO and drives them onto the bus in its own slot. Slots alternate every clock: drive slot on phase 0, sample slot on phase 1.

---
 rtl/bus_responder.sv | 130 +++++++++++++
 tb/tb_bus_responder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_responder.sv
// Slotted shared-address-bus endpoint: bus samples land in an rx FIFO for the
// local req port, and local responses queue in a tx FIFO for the drive slot.
module bus_responder_fifo #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 4,
  localparam int AW     = $clog2(DEPTH),
  localparam int CW     = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [DATA_W-1:0] din_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] dout_o,
  output logic [CW-1:0]     count_o
);
  logic [DEPTH-1:0][DATA_W-1:0] mem_q;
  logic [AW-1:0]                wr_q, rd_q;
  logic [CW-1:0]                cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (push_i && !pop_i)      cnt_d = cnt_q + 1'b1;
    else if (pop_i && !push_i) cnt_d = cnt_q - 1'b1;
  end

  // Pointers are AW bits wide so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_q];
  assign count_o = cnt_q;
endmodule

module bus_responder #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 4,
  localparam int CW     = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  inout  wire  [DATA_W-1:0] bus_addr,
  inout  wire               bus_vld,
  output logic              bus_oe,
  output logic              phase,
  output logic [DATA_W-1:0] req_addr,
  output logic              req_valid,
  input  logic              req_ready,
  input  logic [DATA_W-1:0] rsp_data,
  input  logic              rsp_valid,
  output logic              rsp_ready,
  output logic [CW-1:0]     rx_count,
  output logic [CW-1:0]     tx_count,
  output logic              overflow
);
  logic              phase_q;
  logic              ovf_q, ovf_d;
  logic              drive, smp_vld, rx_full;
  logic              tx_push, rx_push, rx_pop;
  logic [DATA_W-1:0] tx_head, rx_head;

  // Drive is purely a function of registered state, so an async reset that
  // clears tx_count releases the bus without waiting for an edge.
  assign drive     = !phase_q && (tx_count != '0);
  assign rsp_ready = (tx_count != CW'(DEPTH));
  assign tx_push   = rsp_valid && rsp_ready;

  // A full rx drops the sample even if req_ready frees a slot this cycle.
  assign smp_vld   = phase_q && (bus_vld == 1'b1);
  assign rx_full   = (rx_count == CW'(DEPTH));
  assign rx_push   = smp_vld && !rx_full;
  assign req_valid = (rx_count != '0);
  assign rx_pop    = req_valid && req_ready;
  assign req_addr  = req_valid ? rx_head : '0;

  assign bus_oe    = drive;
  assign phase     = phase_q;
  assign bus_addr  = drive ? tx_head : {DATA_W{1'bz}};
  assign bus_vld   = drive ? 1'b1 : 1'bz;

  always_comb begin
    ovf_d = ovf_q;
    if (smp_vld && rx_full) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      phase_q <= !phase_q;
      ovf_q   <= ovf_d;
    end
  end

  assign overflow = ovf_q;

  bus_responder_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_tx (
    .clk     (clk),
    .rst     (rst),
    .push_i  (tx_push),
    .din_i   (rsp_data),
    .pop_i   (drive),
    .dout_o  (tx_head),
    .count_o (tx_count)
  );

  bus_responder_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_rx (
    .clk     (clk),
    .rst     (rst),
    .push_i  (rx_push),
    .din_i   (bus_addr),
    .pop_i   (rx_pop),
    .dout_o  (rx_head),
    .count_o (rx_count)
  );
endmodule

// File: tb/tb_bus_responder.sv
// Scoreboard bench for bus_responder: stimulus queues expected bus/req words,
// negedge monitors pop and compare whenever the DUT presents a word.
module tb_bus_responder;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  wire  [DW-1:0] bus_addr;
  wire           bus_vld;
  logic          bus_oe, phase;
  logic [DW-1:0] req_addr;
  logic          req_valid;
  logic          req_ready = 1'b0;
  logic [DW-1:0] rsp_data  = '0;
  logic          rsp_valid = 1'b0;
  logic          rsp_ready;
  logic [CW-1:0] rx_count, tx_count;
  logic          overflow;

  logic [DW-1:0] tb_addr = '0;
  logic          tb_vld  = 1'b0;
  bit            saw_full = 1'b0;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] exp_tx[$];
  logic [DW-1:0] exp_rx[$];

  // Bench owns the bus during sample slots; DUT owns it during drive slots.
  assign bus_addr = phase ? tb_addr : {DW{1'bz}};
  assign bus_vld  = phase ? tb_vld  : 1'bz;

  always #5 clk = ~clk;

  bus_responder #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus_addr  (bus_addr),
    .bus_vld   (bus_vld),
    .bus_oe    (bus_oe),
    .phase     (phase),
    .req_addr  (req_addr),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .rsp_data  (rsp_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rx_count  (rx_count),
    .tx_count  (tx_count),
    .overflow  (overflow)
  );

  function automatic void chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0h req=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      chk("oe_phase_excl", int'(bus_oe & phase), 0);
      if (bus_oe) begin
        if (exp_tx.size() == 0) begin
          total++; bad++;
          $display("FAIL bus_unexpected act=%0h req=none at %0t", bus_addr, $time);
        end else begin
          chk("bus_addr", int'(bus_addr), int'(exp_tx.pop_front()));
          chk("bus_vld", int'(bus_vld), 1);
        end
      end
      if (req_valid && req_ready) begin
        if (exp_rx.size() == 0) begin
          total++; bad++;
          $display("FAIL req_unexpected act=%0h req=none at %0t", req_addr, $time);
        end else begin
          chk("req_addr", int'(req_addr), int'(exp_rx.pop_front()));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_phase(input logic p);
    int n = 0;
    while (phase != p && n < 4) begin
      tick();
      n++;
    end
    chk("wait_phase", int'(phase), int'(p));
  endtask

  task automatic send_bus(input logic [DW-1:0] d, input bit acc);
    wait_phase(1'b1);
    tb_addr = d;
    tb_vld  = 1'b1;
    if (acc) exp_rx.push_back(d);
    tick();
    tb_vld  = 1'b0;
  endtask

  task automatic push_rsp(input logic [DW-1:0] d);
    int n = 0;
    rsp_data  = d;
    rsp_valid = 1'b1;
    while (!rsp_ready && n < 20) begin
      saw_full = 1'b1;
      chk("tx_full_count", int'(tx_count), DEPTH);
      tick();
      n++;
    end
    chk("rsp_ready_wait", int'(rsp_ready), 1);
    exp_tx.push_back(d);
    tick();
  endtask

  task automatic wait_rx_empty();
    int n = 0;
    while (rx_count != 0 && n < 40) begin
      tick();
      n++;
    end
    chk("rx_drain_count", int'(rx_count), 0);
    chk("rx_drain_queue", exp_rx.size(), 0);
  endtask

  task automatic wait_tx_empty();
    int n = 0;
    while (tx_count != 0 && n < 60) begin
      tick();
      n++;
    end
    tick();
    chk("tx_drain_count", int'(tx_count), 0);
    chk("tx_drain_queue", exp_tx.size(), 0);
  endtask

  initial begin
    #1 rst = 1'b0;
    #2;
    chk("rst_phase", int'(phase), 0);
    chk("rst_oe", int'(bus_oe), 0);
    chk("rst_req_valid", int'(req_valid), 0);
    chk("rst_req_addr", int'(req_addr), 0);
    chk("rst_rsp_ready", int'(rsp_ready), 1);
    chk("rst_rx_count", int'(rx_count), 0);
    chk("rst_tx_count", int'(tx_count), 0);
    chk("rst_overflow", int'(overflow), 0);
    repeat (2) tick();
    rst = 1'b1;

    // Reset during a drive slot with two words queued: bus released at once.
    rsp_data = 8'h11; rsp_valid = 1'b1;
    tick();
    rsp_data = 8'h22;
    tick();
    rsp_valid = 1'b0;
    chk("pre_rst_tx_count", int'(tx_count), 2);
    chk("pre_rst_oe", int'(bus_oe), 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_oe", int'(bus_oe), 0);
    chk("mid_rst_phase", int'(phase), 0);
    chk("mid_rst_tx_count", int'(tx_count), 0);
    chk("mid_rst_rx_count", int'(rx_count), 0);
    chk("mid_rst_rsp_ready", int'(rsp_ready), 1);
    chk("mid_rst_overflow", int'(overflow), 0);
    tick();
    rst = 1'b1;
    tick();
    chk("post_rst_phase", int'(phase), 1);

    // Receive path, one-cycle latency to req_valid.
    req_ready = 1'b1;
    send_bus(8'hA5, 1'b1);
    chk("rx_lat_valid", int'(req_valid), 1);
    chk("rx_lat_addr", int'(req_addr), 8'hA5);
    tick();
    chk("rx_popped_count", int'(rx_count), 0);

    // Transmit path.
    push_rsp(8'h3C);
    push_rsp(8'hC3);
    rsp_valid = 1'b0;
    wait_tx_empty();

    // Rx overflow: fifth sample dropped, first four kept in order.
    req_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      send_bus(DW'(i), i <= DEPTH);
      if (i == DEPTH) chk("ovf_before", int'(overflow), 0);
    end
    chk("ovf_rx_count", int'(rx_count), DEPTH);
    chk("ovf_set", int'(overflow), 1);
    req_ready = 1'b1;
    wait_rx_empty();
    chk("ovf_sticky", int'(overflow), 1);

    // Tx fill, back-pressure and pointer wrap over ten words.
    for (int i = 0; i < 10; i++) push_rsp(DW'(i));
    rsp_valid = 1'b0;
    wait_tx_empty();
    chk("tx_saw_full", int'(saw_full), 1);

    // Simultaneous rx push and pop.
    req_ready = 1'b0;
    send_bus(8'h70, 1'b1);
    send_bus(8'h71, 1'b1);
    chk("sim_pre_count", int'(rx_count), 2);
    wait_phase(1'b1);
    tb_addr = 8'h72;
    tb_vld  = 1'b1;
    req_ready = 1'b1;
    exp_rx.push_back(8'h72);
    tick();
    tb_vld = 1'b0;
    req_ready = 1'b0;
    chk("sim_count", int'(rx_count), 2);
    req_ready = 1'b1;
    wait_rx_empty();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout req=finish");
    $fatal(1, "watchdog");
  end
endmodule
